seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of the stopwatch counter. It takes the four BCD digits (10 ms, 100 ms, 1 s, 10 s) and scans them onto a common-anode LED display, one digit per slot. It provides inter-digit blanking against ghosting, frame-coherent digit capture to prevent tearing, leading-zero suppression and a decimal-point mask. All outputs are registered.

## Interface
- P_CNT_SCAN, 95999: slot length minus 1, in clk cycles. The default gives 1 ms per digit at 96 MHz.
- P_BLANK, 4800: cycles at the start of each slot during which all anodes are off. Legal range is 0 .. P_CNT_SCAN-1.
- P_ACTIVE_LOW, 1: when 1, seg/dp/an are active-low; when 0, they are active-high.
- clk  in  1  system clock
- rstb  in  1  reset; one clock; reset is asynchronous and active-low
- t_10ms  in  4  BCD digit 0 (rightmost)
- t_100ms  in  4  BCD digit 1
- t_1s  in  4  BCD digit 2
- t_10s  in  4  BCD digit 3 (leftmost)
- dp_mask  in  4  bit n lights the decimal point on digit n; the stopwatch uses 4'b0100
- lz_en  in  1  1 = blank digit 3 when its captured value is 0
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  4  anode enables; bit n selects digit n

## Operation
- Counters:
  - scan_cnt (17 bits) runs 0..P_CNT_SCAN and wraps to 0.
  - dig_idx (2 bits) increments on each wrap: 0→1→2→3→0.
- One slot is P_CNT_SCAN+1 cycles. One frame is 4 slots, digit 0 first.
- States per slot: BLANK while scan_cnt < P_BLANK, DRIVE otherwise. With P_BLANK=0 the block is always in DRIVE.
- BLANK: an, seg and dp are all inactive.
- DRIVE:
  - an: only bit dig_idx is active.
  - seg: decode of the captured digit.
  - dp: active iff dp_mask[dig_idx] = 1.
- Snapshot: four 4-bit registers load t_10ms..t_10s when scan_cnt==P_CNT_SCAN and dig_idx==3 (last cycle of the frame). The whole next frame displays that snapshot, so input changes mid-frame never mix.
- dp_mask and lz_en are sampled live, not snapshotted.
- Decode of the active-sense pattern {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 = 1000000 (dash only), used as an error indicator.
- Leading-zero suppression: if lz_en=1 and the captured digit 3 is 0, digit 3's slot behaves as BLANK for seg only. an still activates; seg is all off; dp still follows dp_mask. Digits 0..2 are never suppressed.
- Polarity: when P_ACTIVE_LOW=1, every output is the bitwise inverse of the active-sense value.

## Timing
- Reset (rstb=0, asynchronous):
  - scan_cnt=0, dig_idx=0, snapshot=0.
  - an, seg and dp inactive, i.e. an=4'hF, seg=7'h7F, dp=1 when P_ACTIVE_LOW=1.
- Reset release: counting starts on the first clk edge with rstb=1. The first frame displays the zero snapshot.
- Output latency: outputs are registered, so they reflect the scan_cnt/dig_idx of the previous cycle. an, seg and dp change on the same edge, and there is never a cycle where two anodes are active.
- Slot boundary: the last DRIVE cycle of digit n is followed by P_BLANK all-off cycles, then DRIVE of digit n+1.
- Snapshot update: the snapshot changes on the same edge on which dig_idx wraps 3→0. Digit 0 of the new frame shows the new value.
- Reset asserted mid-slot: outputs go inactive immediately, not waiting for clk, and the scan restarts at digit 0.
- Refresh rate: frame period is 4*(P_CNT_SCAN+1) cycles, which is 4 ms (250 Hz) at the defaults.

## Test plan
All scenarios use P_CNT_SCAN=9, P_BLANK=2, P_ACTIVE_LOW=1.

- Reset/scan order: hold rstb=0 → an=F, seg=7F, dp=1. Release, with inputs 1,2,3,4 (10ms..10s):
  - first frame shows seg=40 (digit 0) on an=E, 8 cycles each slot, preceded by 2 all-off cycles.
  - second frame shows 79, 24, 30, 19 on an=E, D, B, 7.
- Decode sweep: drive t_10ms through 0..15 across frames → digit 0 seg equals the inverse of the table. Values 10..15 give 3F.
- Tear-free capture: change t_1s from 5 to 6 while dig_idx=1 → the rest of the frame shows 5 (seg=12). The next frame shows 6 (seg=02).
- Leading zero: t_10s=0 with lz_en=1 → digit 3 slot has an=7, seg=7F. With lz_en=0 → seg=40.
- Decimal point: dp_mask=4'b0100 → dp=0 only during DRIVE of digit 2. dp=1 during BLANK and in all other slots.
- Async reset mid-DRIVE of digit 2: assert rstb between clock edges → an=F at once. After release the scan restarts at digit 0 and the snapshot is 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Digit/segment bundle between the stopwatch counter and the 4-digit 7-segment scanner.
// master drives BCD digits and display controls; slave drives the LED pins.
interface seg7_scan_if;
  logic [3:0] t_10ms;
  logic [3:0] t_100ms;
  logic [3:0] t_1s;
  logic [3:0] t_10s;
  logic [3:0] dp_mask;
  logic       lz_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output t_10ms, t_100ms, t_1s, t_10s, dp_mask, lz_en,
    input  seg, dp, an
  );

  modport slave (
    input  t_10ms, t_100ms, t_1s, t_10s, dp_mask, lz_en,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with inter-digit blanking,
// frame-coherent digit snapshot, leading-zero suppression and decimal-point mask.
module seg7_scan #(
  parameter int P_CNT_SCAN   = 95999,
  parameter int P_BLANK      = 4800,
  parameter int P_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rstb,
  seg7_scan_if.slave  bus
);

  localparam logic [16:0] CNT_MAX_C = 17'(P_CNT_SCAN);
  localparam logic [16:0] BLANK_C   = 17'(P_BLANK);
  localparam logic        POL_C     = (P_ACTIVE_LOW != 0);

  logic [16:0] scan_cnt_r;
  logic [1:0]  dig_idx_r;
  logic [3:0]  snap0_r, snap1_r, snap2_r, snap3_r;
  logic [3:0]  an_r;
  logic [6:0]  seg_r;
  logic        dp_r;

  logic        wrap_s;
  logic        blank_s;
  logic        lz_hit_s;
  logic [3:0]  cur_dig_s;
  logic [3:0]  an_act_s;
  logic [6:0]  seg_act_s;
  logic        dp_act_s;

  // Active-sense {g,f,e,d,c,b,a}; non-BCD codes show a lone dash as an error marker.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  assign wrap_s = (scan_cnt_r == CNT_MAX_C);

  // Slot counter, digit index and end-of-frame snapshot of the BCD digits.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scan_cnt_r <= 17'd0;
      dig_idx_r  <= 2'd0;
      snap0_r    <= 4'd0;
      snap1_r    <= 4'd0;
      snap2_r    <= 4'd0;
      snap3_r    <= 4'd0;
    end else if (wrap_s) begin
      scan_cnt_r <= 17'd0;
      dig_idx_r  <= dig_idx_r + 2'd1;
      if (dig_idx_r == 2'd3) begin
        snap0_r <= bus.t_10ms;
        snap1_r <= bus.t_100ms;
        snap2_r <= bus.t_1s;
        snap3_r <= bus.t_10s;
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + 17'd1;
    end
  end

  // Active-sense output pattern for the current slot position.
  always_comb begin
    blank_s   = (scan_cnt_r < BLANK_C);
    case (dig_idx_r)
      2'd0:    cur_dig_s = snap0_r;
      2'd1:    cur_dig_s = snap1_r;
      2'd2:    cur_dig_s = snap2_r;
      2'd3:    cur_dig_s = snap3_r;
      default: cur_dig_s = 4'd0;
    endcase
    lz_hit_s  = bus.lz_en && (dig_idx_r == 2'd3) && (snap3_r == 4'd0);
    an_act_s  = 4'b0000;
    seg_act_s = 7'b0000000;
    dp_act_s  = 1'b0;
    if (blank_s) begin
      an_act_s  = 4'b0000;
      seg_act_s = 7'b0000000;
      dp_act_s  = 1'b0;
    end else begin
      an_act_s  = 4'b0001 << dig_idx_r;
      seg_act_s = lz_hit_s ? 7'b0000000 : dec7(cur_dig_s);
      dp_act_s  = bus.dp_mask[dig_idx_r];
    end
  end

  // Registered pins, polarity applied here so reset lands on the all-off pattern.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      an_r  <= {4{POL_C}};
      seg_r <= {7{POL_C}};
      dp_r  <= POL_C;
    end else begin
      an_r  <= an_act_s ^ {4{POL_C}};
      seg_r <= seg_act_s ^ {7{POL_C}};
      dp_r  <= dp_act_s ^ POL_C;
    end
  end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.dp  = dp_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (P_CNT_SCAN=9, P_BLANK=2, active-low): the stimulus
// pushes one expected {an,seg,dp} per cycle, the monitor pops and compares.
module tb_seg7_scan;

  logic clk;
  logic rstb;
  seg7_scan_if bus ();

  seg7_scan #(
    .P_CNT_SCAN  (9),
    .P_BLANK     (2),
    .P_ACTIVE_LOW(1)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          mon_idx  = 0;
  event        samp_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inverted (active-low) segment codes, worked out by hand from the decode table.
  function automatic logic [6:0] dec_inv(input int k);
    logic [6:0] v;
    case (k)
      0:       v = 7'h40;
      1:       v = 7'h79;
      2:       v = 7'h24;
      3:       v = 7'h30;
      4:       v = 7'h19;
      5:       v = 7'h12;
      6:       v = 7'h02;
      7:       v = 7'h78;
      8:       v = 7'h00;
      9:       v = 7'h10;
      default: v = 7'h3F;
    endcase
    return v;
  endfunction

  // Monitor: one sample per clock (1 time unit after the edge) or on explicit request.
  initial begin
    forever begin
      @(posedge clk or samp_ev);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({bus.an, bus.seg, bus.dp} !== mon_e) begin
          failures++;
          $display("FAIL scan[%0d] got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                   mon_idx, bus.an, bus.seg, bus.dp, mon_e[11:8], mon_e[7:1], mon_e[0]);
        end
        mon_idx++;
      end
    end
  end

  // Expected slot sequence: 2 all-off cycles then 8 drive cycles per digit.
  task automatic push_frame(input logic [6:0] e0, e1, e2, e3, input logic [3:0] dpm, input int n);
    logic [6:0]  s;
    logic [3:0]  a;
    int          idx;
    idx = 0;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       s = e0;
        1:       s = e1;
        2:       s = e2;
        default: s = e3;
      endcase
      a = ~(4'b0001 << d);
      for (int c = 0; c < 10; c++) begin
        if (idx < n) begin
          if (c < 2) exp_q.push_back({4'hF, 7'h7F, 1'b1});
          else       exp_q.push_back({a, s, ~dpm[d]});
        end
        idx++;
      end
    end
  endtask

  task automatic set_inputs(input logic [3:0] n0, n1, n2, n3, input logic [3:0] dpm, input logic lz);
    bus.t_10ms  = n0;
    bus.t_100ms = n1;
    bus.t_1s    = n2;
    bus.t_10s   = n3;
    bus.dp_mask = dpm;
    bus.lz_en   = lz;
  endtask

  // Apply next-frame inputs, expect this frame's snapshot, then let the frame run.
  task automatic run_frame(input logic [3:0] n0, n1, n2, n3, input logic [3:0] dpm, input logic lz,
                           input logic [6:0] e0, e1, e2, e3);
    set_inputs(n0, n1, n2, n3, dpm, lz);
    push_frame(e0, e1, e2, e3, dpm, 40);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    rstb = 1'b0;
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.an !== 4'hF) begin
      failures++;
      $display("FAIL reset an=%h expected F", bus.an);
    end
    checks++;
    if (bus.seg !== 7'h7F) begin
      failures++;
      $display("FAIL reset seg=%h expected 7F", bus.seg);
    end
    exp_q.push_back({4'hF, 7'h7F, 1'b1});
    ->samp_ev;
    @(negedge clk);
    rstb = 1'b1;

    run_frame(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40);
    run_frame(4'd0, 4'd8, 4'd5, 4'd0, 4'b0100, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19);
    run_frame(4'd2, 4'd9, 4'd5, 4'd0, 4'b0100, 1'b1, 7'h40, 7'h00, 7'h12, 7'h7F);

    // t_1s moves 5->6 during digit 1; this frame must still show 5.
    set_inputs(4'd3, 4'd9, 4'd5, 4'd0, 4'b0000, 1'b0);
    push_frame(7'h24, 7'h10, 7'h12, 7'h40, 4'b0000, 40);
    repeat (15) @(negedge clk);
    bus.t_1s = 4'd6;
    repeat (25) @(negedge clk);
    run_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 7'h30, 7'h10, 7'h02, 7'h40);

    for (int k = 0; k <= 16; k++) begin
      run_frame((k < 16) ? 4'(k) : 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0,
                dec_inv((k == 0) ? 0 : k - 1), 7'h40, 7'h40, 7'h40);
    end

    // Async reset while digit 2 is being driven.
    set_inputs(4'd7, 4'd7, 4'd7, 4'd7, 4'b0100, 1'b0);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0100, 25);
    repeat (25) @(negedge clk);
    #2;
    rstb = 1'b0;
    exp_q.push_back({4'hF, 7'h7F, 1'b1});
    ->samp_ev;
    #1;
    checks++;
    if (bus.an !== 4'hF) begin
      failures++;
      $display("FAIL async reset an=%h expected F", bus.an);
    end
    checks++;
    if (bus.dp !== 1'b1) begin
      failures++;
      $display("FAIL async reset dp=%b expected 1", bus.dp);
    end
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    run_frame(4'd5, 4'd5, 4'd5, 4'd5, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40);
    run_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 7'h12, 7'h12, 7'h12, 7'h12);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
